uart_tx: RTL and testbench
==========================

// Module: uart_tx
// PURPOSE
//  UART transmitter, counterpart of uart_rx. Serialises parallel words onto line tx:
//  1 start bit (0), WIDTH data bits LSB first, optional parity bit, 1..2 stop bits (1).
//  Sits between an internal producer (valid/ready handshake) and the device pin.
//  One-entry holding register allows back-to-back frames with no idle gap.
// PARAMETERS
//  WIDTH      8         data bits per frame (5..9)
//  FCLK       50000000  clk50m frequency in Hz
//  FBAUD      115200    line baud rate; bit period BITCYC = FCLK/FBAUD clocks (integer div)
//  PARITY     0         0 = none, 1 = odd, 2 = even
//  STOP_BITS  1         number of stop bits, 1 or 2
// PORTS
//  clk50m    in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  tx_data   in   WIDTH  word to send, sampled when tx_valid & tx_ready
//  tx_valid  in   1      producer has a word
//  tx_ready  out  1      holding register empty, word accepted this edge if tx_valid
//  tx        out  1      serial line, idle high, registered
//  tx_busy   out  1      frame in progress (state != IDLE)
//  tx_done   out  1      one-cycle pulse at end of last stop bit
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): tx=1, tx_ready=1, tx_busy=0, tx_done=0,
//    state IDLE, holding reg empty, counters 0. Partial frame discarded, no resume.
//  - Handshake: accept on edge with tx_valid & tx_ready; hold_full set, tx_ready=0 next cycle.
//    tx_valid with tx_ready=0 ignored; producer keeps tx_data stable until accepted.
//  - tx_ready = ~hold_full; a new word may be accepted while a frame is being sent.
//  - FSM states IDLE, START, DATA, PARITY, STOP:
//    IDLE:   tx=1; if hold_full: load shift reg from hold, clear hold_full, load baud cnt,
//            -> START. tx goes low on the edge after acceptance (latency 1 clk).
//    START:  tx=0 for BITCYC clks -> DATA, bit index 0.
//    DATA:   tx=shift[0] for BITCYC clks, shift right; after bit WIDTH-1 -> PARITY if
//            PARITY!=0 else STOP.
//    PARITY: tx = ^data (even) or ~^data (odd), BITCYC clks -> STOP.
//    STOP:   tx=1 for STOP_BITS*BITCYC clks; at final clk pulse tx_done; then if hold_full
//            load next word and -> START directly (zero-gap), else -> IDLE.
//  - Baud counter: loads BITCYC-1 at each bit start, decrements to 0; bit ends on zero.
//    Width $clog2(BITCYC). Every bit lasts exactly BITCYC clks; frame =
//    (1+WIDTH+(PARITY!=0)+STOP_BITS)*BITCYC clks.
//  - Parity computed from word captured in shift reg at START, not from live tx_data.
//  - Drain of hold into shift and a new accept can never coincide (ready low while full);
//    tx_ready rises the cycle after drain.
//  - Illegal state encodings -> IDLE with tx=1.
// STRUCTURE
//  - uart_pkg: state enum (shared with uart_rx), PARITY_NONE/ODD/EVEN constants,
//    function bitcyc(FCLK,FBAUD).
//  - Sub-module uart_baudgen: loadable down-counter with load/zero ports, reusable by uart_rx.
//  - FSM, shift reg, holding reg, bit counter in uart_tx.
// TESTING (FCLK=50000000, FBAUD=5000000 -> BITCYC=10 unless noted)
//  1 Send 0x55, PARITY=0, STOP_BITS=1 -> tx: 0,1,0,1,0,1,0,1,0,1 each 10 clks; tx_done
//    pulse at clk 100 after first low; tx_busy high exactly 100 clks.
//  2 Send 0x07, PARITY=2 -> parity bit 1; PARITY=1 -> parity bit 0; frame 110 clks.
//  3 0xA5 then 0x3C offered back-to-back -> second accepted during first frame, tx_ready 0
//    until drain; second start bit immediately after first stop, no idle clk (200 clks total).
//  4 tx_valid held with tx_ready=0 and tx_data toggling -> only value present at accept sent.
//  5 Assert rst at clk 45 of frame 0xFF -> tx=1 and tx_busy=0 immediately; next 0x81 correct.
//  6 Defaults (FBAUD=115200): BITCYC=434, 0x41 frame 4340 clks, bit edges +/-0 clk.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by uart_tx and uart_rx:
//   uart_state_e  frame state machine encoding
//   PARITY_*      values accepted by the PARITY parameter
//   bitcyc()      clocks per bit for a given clock and baud rate (integer divide)
//   cnt_width()   width of a down-counter that must hold bitcyc()-1
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int bitcyc(input int fclk, input int fbaud);
    return fclk / fbaud;
  endfunction

  // $clog2(1) is 0, so keep at least one bit for degenerate rates.
  function automatic int cnt_width(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// -----------------------------------------------------------------------------
// uart_baudgen
// Loadable down-counter that times one bit period. Load it with BITCYC-1 at the
// start of a bit; 'zero' is high during the last clock of that bit.
// Ports:
//   clk50m    in   system clock
//   rst       in   asynchronous reset, active-high (counter to 0)
//   load      in   load load_val on the next edge (overrides counting)
//   load_val  in   reload value
//   zero      out  counter currently at 0
// -----------------------------------------------------------------------------
module uart_baudgen #(
  parameter int CNT_W = 4
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit (0), WIDTH data bits LSB first, optional parity
// bit, STOP_BITS stop bits (1). A one-entry holding register lets the producer
// hand over the next word while a frame is on the line, so frames can go out
// back to back with no idle clock in between.
// Ports:
//   clk50m    in   system clock
//   rst       in   asynchronous reset, active-high
//   tx_data   in   word to send, taken when tx_valid & tx_ready
//   tx_valid  in   producer offers tx_data
//   tx_ready  out  holding register empty
//   tx        out  serial line, idle high, registered
//   tx_busy   out  frame in progress
//   tx_done   out  one-clock pulse right after the last stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FCLK      = 50000000,
  parameter int FBAUD     = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

  localparam int BITCYC = bitcyc(FCLK, FBAUD);
  localparam int CNT_W  = cnt_width(BITCYC);
  localparam int IDX_W  = 4;  // covers up to 9 data bits and 2 stop bits

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BITCYC - 1);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             par_q, par_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             baud_load, baud_zero;
  logic             load_word;

  uart_baudgen #(.CNT_W(CNT_W)) u_baud (
    .clk50m   (clk50m),
    .rst      (rst),
    .load     (baud_load),
    .load_val (BIT_LOAD),
    .zero     (baud_zero)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    idx_d       = idx_q;
    tx_d        = tx_q;
    done_d      = 1'b0;
    baud_load   = 1'b0;
    load_word   = 1'b0;

    // Accept only into an empty holding register; a drain needs it full, so the
    // two can never happen on the same edge.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (hold_full_q) load_word = 1'b1;
      end
      ST_START: begin
        if (baud_zero) begin
          state_d   = ST_DATA;
          idx_d     = '0;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          baud_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (baud_zero) begin
          baud_load = 1'b1;
          if (idx_q == LAST_DATA) begin
            idx_d = '0;
            if (PARITY != PARITY_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_zero) begin
          state_d   = ST_STOP;
          idx_d     = '0;
          tx_d      = 1'b1;
          baud_load = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_zero) begin
          if (idx_q == LAST_STOP) begin
            done_d = 1'b1;
            if (hold_full_q) begin
              load_word = 1'b1;  // zero-gap: next start bit follows directly
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            baud_load = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Move the held word into the shifter and begin the start bit. Parity is
    // taken from this captured word, never from the live input.
    if (load_word) begin
      state_d     = ST_START;
      shift_d     = hold_q;
      par_d       = (PARITY == PARITY_ODD) ? ~^hold_q : ^hold_q;
      hold_full_d = 1'b0;
      idx_d       = '0;
      tx_d        = 1'b0;
      baud_load   = 1'b1;
    end
  end

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ~hold_full_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic [4:0] valid_r;
  logic [4:0] ready_w, tx_w, busy_w, done_w;

  int n_pass  = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  // u0: 10 clk/bit, no parity, 1 stop
  uart_tx #(.FBAUD(5000000)) u0 (
    .clk50m(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_r[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  // u1: even parity
  uart_tx #(.FBAUD(5000000), .PARITY(2)) u1 (
    .clk50m(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_r[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  // u2: odd parity
  uart_tx #(.FBAUD(5000000), .PARITY(1)) u2 (
    .clk50m(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_r[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  // u3: all defaults (434 clk/bit)
  uart_tx u3 (
    .clk50m(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_r[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
  // u4: odd parity, 2 stop bits
  uart_tx #(.FBAUD(5000000), .PARITY(1), .STOP_BITS(2)) u4 (
    .clk50m(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid_r[4]),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Frame bit b (0 = start bit); unused high positions stay 1 (stop/idle).
  function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit has_par, input bit par);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (has_par) f[9] = par;
    return f;
  endfunction

  // Call at #1 after a posedge. Offers a word, waits for acceptance, drops valid.
  task automatic drive_word(input int k, input logic [7:0] d);
    int t;
    t = 0;
    tx_data    = d;
    valid_r[k] = 1'b1;
    while (ready_w[k] !== 1'b1 && t < 300) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 300) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    valid_r[k] = 1'b0;
  endtask

  // Waits for the start bit, then checks tx/busy/done on every clock of nfr
  // consecutive frames, plus the done pulse and return to idle afterwards.
  task automatic check_stream(input int k, input int bc, input int nbits,
                              input logic [15:0] f0, input logic [15:0] f1, input int nfr);
    int t, flen, fr, b;
    logic e;
    t = 0;
    while (tx_w[k] !== 1'b0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      chk("start_timeout", 32'd1, 32'd0);
      return;
    end
    flen = nbits * bc;
    for (int c = 0; c < nfr * flen; c++) begin
      fr = c / flen;
      b  = (c % flen) / bc;
      e  = (fr == 0) ? f0[b] : f1[b];
      chk("tx_bit", {31'd0, tx_w[k]}, {31'd0, e});
      chk("busy_in_frame", {31'd0, busy_w[k]}, 32'd1);
      chk("done_in_frame", {31'd0, done_w[k]}, (c > 0 && c % flen == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    chk("done_pulse", {31'd0, done_w[k]}, 32'd1);
    chk("busy_end", {31'd0, busy_w[k]}, 32'd0);
    chk("tx_idle", {31'd0, tx_w[k]}, 32'd1);
    @(posedge clk); #1;
    chk("done_clear", {31'd0, done_w[k]}, 32'd0);
    $display("uart%0d: %0d frame(s) of %0d clks checked, f0=%h f1=%h", k, nfr, flen, f0, f1);
  endtask

  initial begin
    int t;
    rst     = 1'b1;
    valid_r = '0;
    tx_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx",    {27'd0, tx_w},    32'h1f);
    chk("rst_ready", {27'd0, ready_w}, 32'h1f);
    chk("rst_busy",  {27'd0, busy_w},  32'h0);
    chk("rst_done",  {27'd0, done_w},  32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: 0x55, no parity
    fork
      drive_word(0, 8'h55);
      check_stream(0, 10, 10, mk_frame(8'h55, 0, 0), 16'hffff, 1);
    join

    // 2: 0x07 even parity -> 1, odd parity -> 0
    fork
      drive_word(1, 8'h07);
      check_stream(1, 10, 11, mk_frame(8'h07, 1, 1'b1), 16'hffff, 1);
    join
    fork
      drive_word(2, 8'h07);
      check_stream(2, 10, 11, mk_frame(8'h07, 1, 1'b0), 16'hffff, 1);
    join

    // 3: back-to-back 0xA5, 0x3C with no idle clock
    fork
      begin
        drive_word(0, 8'hA5);
        chk("ready_low_after_accept", {31'd0, ready_w[0]}, 32'd0);
        drive_word(0, 8'h3C);
      end
      check_stream(0, 10, 10, mk_frame(8'hA5, 0, 0), mk_frame(8'h3C, 0, 0), 2);
    join

    // 4: data toggles while valid is held and ready is low; only 0x22 is sent
    fork
      begin
        drive_word(0, 8'h11);
        drive_word(0, 8'h22);
        for (int i = 0; i < 40; i++) begin
          tx_data    = 8'($urandom);
          valid_r[0] = 1'b1;
          chk("ready_held_low", {31'd0, ready_w[0]}, 32'd0);
          @(posedge clk); #1;
        end
        valid_r[0] = 1'b0;
      end
      check_stream(0, 10, 10, mk_frame(8'h11, 0, 0), mk_frame(8'h22, 0, 0), 2);
    join

    // 5: async reset at clk 45 of a 0xFF frame, then a clean 0x81
    drive_word(0, 8'hFF);
    t = 0;
    while (tx_w[0] !== 1'b0 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("rst_test_start", {31'd0, tx_w[0]}, 32'd0);
    repeat (45) @(posedge clk);
    #5 rst = 1'b1;
    #1;
    chk("midrst_tx",    {31'd0, tx_w[0]},    32'd1);
    chk("midrst_busy",  {31'd0, busy_w[0]},  32'd0);
    chk("midrst_ready", {31'd0, ready_w[0]}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("uart0: reset asserted mid-frame");
    fork
      drive_word(0, 8'h81);
      check_stream(0, 10, 10, mk_frame(8'h81, 0, 0), 16'hffff, 1);
    join

    // 6: defaults, 434 clk/bit
    fork
      drive_word(3, 8'h41);
      check_stream(3, 434, 10, mk_frame(8'h41, 0, 0), 16'hffff, 1);
    join

    // 7: odd parity of 0x00 is 1, two stop bits
    fork
      drive_word(4, 8'h00);
      check_stream(4, 10, 12, mk_frame(8'h00, 1, 1'b1), 16'hffff, 1);
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
